// File: rtl/ariane_pkg.sv
// Shared definitions for the hardware performance monitor: CSR addresses,
// event identifiers and address-decode helpers.
package ariane_pkg;

   localparam int unsigned XLEN = 64;

   // Counter banks span mhpm*3 .. mhpm*31.
   localparam int unsigned HPM_MAX_COUNTERS = 29;

   localparam logic [11:0] CSR_MCOUNTINHIBIT     = 12'h320;
   localparam logic [11:0] CSR_MHPM_EVENT_3      = 12'h323;
   localparam logic [11:0] CSR_MHPM_COUNTER_3    = 12'hB03;
   localparam logic [11:0] CSR_MHPM_COUNTER_3H   = 12'hB83;
   localparam logic [11:0] CSR_MHPM_OVF          = 12'h7C0;
   localparam logic [11:0] CSR_MHPM_OVFIE        = 12'h7C1;
   localparam logic [11:0] CSR_MHPM_THRESHOLD_3  = 12'h7E0;
   localparam logic [11:0] CSR_MHPM_THRESHOLD_3H = 12'h7A0;

   typedef enum logic [7:0] {
      EV_NONE           = 8'd0,
      EV_L1_ICACHE_MISS = 8'd1,
      EV_L1_DCACHE_MISS = 8'd2,
      EV_ITLB_MISS      = 8'd3,
      EV_DTLB_MISS      = 8'd4,
      EV_LOAD           = 8'd5,
      EV_STORE          = 8'd6,
      EV_BRANCH         = 8'd7,
      EV_MISPREDICT     = 8'd8,
      EV_CALL           = 8'd9,
      EV_RETURN         = 8'd10,
      EV_SB_FULL        = 8'd11,
      EV_IF_EMPTY       = 8'd12,
      EV_STALL          = 8'd13
   } hpm_event_e;

   typedef enum logic [3:0] {
      CSR_SEL_NONE,
      CSR_SEL_CNT_LO,
      CSR_SEL_CNT_HI,
      CSR_SEL_EVENT,
      CSR_SEL_INHIBIT,
      CSR_SEL_OVF,
      CSR_SEL_OVFIE,
      CSR_SEL_THR_LO,
      CSR_SEL_THR_HI
   } hpm_csr_sel_e;

   // True when addr falls inside the 29-entry bank starting at base.
   function automatic logic hpm_bank_hit(input logic [11:0] addr, input logic [11:0] base);
      return (addr - base) < 12'(HPM_MAX_COUNTERS);
   endfunction

   // Counter index of addr within the bank starting at base.
   function automatic logic [4:0] hpm_bank_idx(input logic [11:0] addr, input logic [11:0] base);
      return 5'(addr - base);
   endfunction

endpackage

// File: rtl/hpm_counter_slice.sv
// One performance counter: event select, increment with wrap, CSR write
// priority, sticky overflow flag and (with HPM_THRESHOLD_EN) threshold compare.
module hpm_counter_slice #(
   parameter int unsigned CntWidth  = 64,
   parameter int unsigned NumEvents = 32,
   parameter int unsigned IncWidth  = 2
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                en_i,
   input  logic [NumEvents-1:0][IncWidth-1:0]  event_inc_i,
   input  logic                                cnt_we_i,
   input  logic [CntWidth-1:0]                 cnt_wval_i,
   input  logic                                sel_we_i,
   input  logic [7:0]                          sel_wval_i,
   input  logic                                ovf_clr_i,
   input  logic                                thr_we_i,
   input  logic [CntWidth-1:0]                 thr_wval_i,
   output logic [CntWidth-1:0]                 cnt_o,
   output logic [7:0]                          sel_o,
   output logic                                ovf_o,
   output logic [CntWidth-1:0]                 thr_o,
   output logic                                thr_hit_o
);

   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [7:0]          sel_q, sel_d;
   logic                ovf_q, ovf_d;
   logic [IncWidth-1:0] inc;
   logic [CntWidth-1:0] sum;
   logic                carry;

   // Pick the selected event's increment; selector 0 or out of range counts nothing.
   always_comb begin
      inc = '0;
      for (int e = 0; e < int'(NumEvents); e++) begin
         if (sel_q == 8'(e)) inc = event_inc_i[e];
      end
      if (sel_q == 8'd0) inc = '0;
      {carry, sum} = {1'b0, cnt_q} + (CntWidth + 1)'(inc);
   end

   // Next state: selector write clears, CSR write beats increment, new overflow beats W1C.
   always_comb begin
      cnt_d = cnt_q;
      sel_d = sel_q;
      ovf_d = ovf_q;
      if (ovf_clr_i) ovf_d = 1'b0;
      if (sel_we_i) begin
         sel_d = sel_wval_i;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (cnt_we_i) begin
         cnt_d = cnt_wval_i;
      end else if (en_i) begin
         cnt_d = sum;
         if (carry) ovf_d = 1'b1;
      end
   end

   // Counter state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         sel_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sel_q <= sel_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign sel_o = sel_q;
   assign ovf_o = ovf_q;

`ifdef HPM_THRESHOLD_EN
   logic [CntWidth-1:0] thr_q;

   // Threshold register, written through its own CSR.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) thr_q <= '0;
      else if (thr_we_i) thr_q <= thr_wval_i;
   end

   assign thr_o     = thr_q;
   assign thr_hit_o = (thr_q != '0) && (cnt_q >= thr_q);
`else
   logic unused_thr;
   assign unused_thr = ^{thr_we_i, thr_wval_i};
   assign thr_o      = '0;
   assign thr_hit_o  = 1'b0;
`endif

endmodule

// File: rtl/hpm_counter_unit.sv
// Hardware performance monitor: NumCounters programmable counters behind a
// CSR port with one-cycle read latency and a level overflow interrupt.
// Optional feature macro: HPM_THRESHOLD_EN adds per-counter threshold registers
// whose crossing also raises irq_o.
module hpm_counter_unit import ariane_pkg::*; #(
   parameter int unsigned NumCounters = 6,
   parameter int unsigned CntWidth    = 64,
   parameter int unsigned NumEvents   = 32,
   parameter int unsigned IncWidth    = 2
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                debug_mode_i,
   input  logic                                req_i,
   input  logic                                we_i,
   input  logic [11:0]                         addr_i,
   input  logic [XLEN-1:0]                     wdata_i,
   output logic [XLEN-1:0]                     rdata_o,
   output logic                                rvalid_o,
   output logic                                err_o,
   input  logic [NumEvents-1:0][IncWidth-1:0]  event_inc_i,
   output logic                                irq_o
);

   hpm_csr_sel_e           csr_sel;
   logic [4:0]             csr_idx;
   logic                   dec_err;
   logic                   acc_en;
   logic                   wr_en;
   logic [XLEN-1:0]        rd_val;
   logic [63:0]            wdata_ext;

   logic [31:0]            inhibit_q, inhibit_d;
   logic [NumCounters-1:0] ovfie_q, ovfie_d;
   logic                   rvalid_q, rvalid_d;
   logic                   err_q, err_d;
   logic [XLEN-1:0]        rdata_q, rdata_d;
   logic                   irq_q, irq_d;

   logic [CntWidth-1:0]    cnt_arr [NumCounters];
   logic [CntWidth-1:0]    thr_arr [NumCounters];
   logic [63:0]            cnt_ext [NumCounters];
   logic [63:0]            thr_ext [NumCounters];
   logic [7:0]             sel_arr [NumCounters];
   logic [NumCounters-1:0] ovf_vec;
   logic [NumCounters-1:0] thr_hit;

   // With a 32-bit CSR port a write replaces only the addressed half.
   function automatic logic [63:0] merge_write(input logic [63:0] old, input logic [63:0] wd,
                                               input logic hi);
      if (XLEN == 32) return hi ? {wd[31:0], old[31:0]} : {old[63:32], wd[31:0]};
      return wd;
   endfunction

   assign wdata_ext = 64'(wdata_i);

   // Decode the CSR address into a register class and counter index.
   always_comb begin
      csr_sel = CSR_SEL_NONE;
      csr_idx = '0;
      if (addr_i == CSR_MCOUNTINHIBIT) begin
         csr_sel = CSR_SEL_INHIBIT;
      end else if (addr_i == CSR_MHPM_OVF) begin
         csr_sel = CSR_SEL_OVF;
      end else if (addr_i == CSR_MHPM_OVFIE) begin
         csr_sel = CSR_SEL_OVFIE;
      end else if (hpm_bank_hit(addr_i, CSR_MHPM_COUNTER_3)) begin
         csr_sel = CSR_SEL_CNT_LO;
         csr_idx = hpm_bank_idx(addr_i, CSR_MHPM_COUNTER_3);
      end else if (hpm_bank_hit(addr_i, CSR_MHPM_COUNTER_3H)) begin
         csr_sel = CSR_SEL_CNT_HI;
         csr_idx = hpm_bank_idx(addr_i, CSR_MHPM_COUNTER_3H);
      end else if (hpm_bank_hit(addr_i, CSR_MHPM_EVENT_3)) begin
         csr_sel = CSR_SEL_EVENT;
         csr_idx = hpm_bank_idx(addr_i, CSR_MHPM_EVENT_3);
      end
`ifdef HPM_THRESHOLD_EN
      else if (hpm_bank_hit(addr_i, CSR_MHPM_THRESHOLD_3)) begin
         csr_sel = CSR_SEL_THR_LO;
         csr_idx = hpm_bank_idx(addr_i, CSR_MHPM_THRESHOLD_3);
      end else if (hpm_bank_hit(addr_i, CSR_MHPM_THRESHOLD_3H)) begin
         csr_sel = CSR_SEL_THR_HI;
         csr_idx = hpm_bank_idx(addr_i, CSR_MHPM_THRESHOLD_3H);
      end
`endif
   end

   // Reject unmapped addresses, unimplemented counters and high halves on a 64-bit port.
   always_comb begin
      dec_err = 1'b0;
      case (csr_sel)
         CSR_SEL_NONE:   dec_err = 1'b1;
         CSR_SEL_CNT_HI,
         CSR_SEL_THR_HI: dec_err = (XLEN != 32) || (32'(csr_idx) >= NumCounters);
         CSR_SEL_CNT_LO,
         CSR_SEL_EVENT,
         CSR_SEL_THR_LO: dec_err = 32'(csr_idx) >= NumCounters;
         default:        dec_err = 1'b0;
      endcase
   end

   assign acc_en = req_i && !dec_err;
   assign wr_en  = acc_en && we_i;

   // Read data mux, zero-extended to XLEN.
   always_comb begin
      rd_val = '0;
      case (csr_sel)
         CSR_SEL_INHIBIT: rd_val = XLEN'(inhibit_q);
         CSR_SEL_OVF:     rd_val = XLEN'(ovf_vec);
         CSR_SEL_OVFIE:   rd_val = XLEN'(ovfie_q);
         default: begin
            for (int k = 0; k < int'(NumCounters); k++) begin
               if (csr_idx == 5'(k)) begin
                  case (csr_sel)
                     CSR_SEL_CNT_LO: rd_val = XLEN'(cnt_ext[k]);
                     CSR_SEL_CNT_HI: rd_val = XLEN'(cnt_ext[k] >> 32);
                     CSR_SEL_EVENT:  rd_val = XLEN'(sel_arr[k]);
                     CSR_SEL_THR_LO: rd_val = XLEN'(thr_ext[k]);
                     CSR_SEL_THR_HI: rd_val = XLEN'(thr_ext[k] >> 32);
                     default:        rd_val = '0;
                  endcase
               end
            end
         end
      endcase
   end

   for (genvar k = 0; k < int'(NumCounters); k++) begin : g_cnt
      logic cnt_we, sel_we, thr_we, ovf_clr, en;

      assign cnt_we  = wr_en && (csr_idx == 5'(k)) &&
                       (csr_sel == CSR_SEL_CNT_LO || csr_sel == CSR_SEL_CNT_HI);
      assign thr_we  = wr_en && (csr_idx == 5'(k)) &&
                       (csr_sel == CSR_SEL_THR_LO || csr_sel == CSR_SEL_THR_HI);
      assign sel_we  = wr_en && (csr_idx == 5'(k)) && (csr_sel == CSR_SEL_EVENT);
      assign ovf_clr = wr_en && (csr_sel == CSR_SEL_OVF) && wdata_i[k];
      assign en      = !debug_mode_i && !inhibit_q[k+3];

      assign cnt_ext[k] = 64'(cnt_arr[k]);
      assign thr_ext[k] = 64'(thr_arr[k]);

      hpm_counter_slice #(
         .CntWidth  (CntWidth),
         .NumEvents (NumEvents),
         .IncWidth  (IncWidth)
      ) u_slice (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .en_i        (en),
         .event_inc_i (event_inc_i),
         .cnt_we_i    (cnt_we),
         .cnt_wval_i  (CntWidth'(merge_write(cnt_ext[k], wdata_ext,
                                             csr_sel == CSR_SEL_CNT_HI))),
         .sel_we_i    (sel_we),
         .sel_wval_i  (wdata_i[7:0]),
         .ovf_clr_i   (ovf_clr),
         .thr_we_i    (thr_we),
         .thr_wval_i  (CntWidth'(merge_write(thr_ext[k], wdata_ext,
                                             csr_sel == CSR_SEL_THR_HI))),
         .cnt_o       (cnt_arr[k]),
         .sel_o       (sel_arr[k]),
         .ovf_o       (ovf_vec[k]),
         .thr_o       (thr_arr[k]),
         .thr_hit_o   (thr_hit[k])
      );
   end

   // Next state of the shared control registers, response and interrupt.
   always_comb begin
      inhibit_d = inhibit_q;
      ovfie_d   = ovfie_q;
      if (wr_en && csr_sel == CSR_SEL_INHIBIT) inhibit_d = wdata_i[31:0];
      if (wr_en && csr_sel == CSR_SEL_OVFIE)   ovfie_d   = wdata_i[NumCounters-1:0];
      rvalid_d = req_i;
      err_d    = req_i && dec_err;
      rdata_d  = acc_en ? rd_val : '0;
      irq_d    = (|(ovf_vec & ovfie_q)) || (|thr_hit);
   end

   // Shared registers; reset also drops any in-flight response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inhibit_q <= '0;
         ovfie_q   <= '0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         inhibit_q <= inhibit_d;
         ovfie_q   <= ovfie_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         irq_q     <= irq_d;
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign err_o    = err_q;
   assign irq_o    = irq_q;

endmodule

// File: tb/tb_hpm_counter_unit.sv
// Directed-vector bench for hpm_counter_unit with default parameters.
module tb_hpm_counter_unit;
   import ariane_pkg::*;

   localparam int NC = 6;
   localparam int CW = 64;
   localparam int NE = 32;
   localparam int IW = 2;

   logic                    clk_i = 1'b0;
   logic                    rst_ni = 1'b0;
   logic                    debug_mode_i = 1'b0;
   logic                    req_i = 1'b0;
   logic                    we_i = 1'b0;
   logic [11:0]             addr_i = '0;
   logic [XLEN-1:0]         wdata_i = '0;
   logic [XLEN-1:0]         rdata_o;
   logic                    rvalid_o;
   logic                    err_o;
   logic [NE-1:0][IW-1:0]   ev = '0;
   logic                    irq_o;

   int n_checks = 0;
   int n_pass   = 0;

   logic            rv, er;
   logic [XLEN-1:0] rd;

   hpm_counter_unit #(
      .NumCounters (NC),
      .CntWidth    (CW),
      .NumEvents   (NE),
      .IncWidth    (IW)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .debug_mode_i (debug_mode_i),
      .req_i        (req_i),
      .we_i         (we_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rdata_o      (rdata_o),
      .rvalid_o     (rvalid_o),
      .err_o        (err_o),
      .event_inc_i  (ev),
      .irq_o        (irq_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time limit, expected finish");
      $fatal(1);
   end

   // One CSR access: request for one cycle, response sampled on the following negedge.
   task automatic csr_access(input logic w, input logic [11:0] a, input logic [XLEN-1:0] d);
      @(negedge clk_i);
      req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
      @(negedge clk_i);
      rv = rvalid_o; rd = rdata_o; er = err_o;
      req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_i);
      n_checks++; if (rvalid_o !== 1'b0) $display("FAIL reset_rvalid: got %0b expected 0", rvalid_o); else n_pass++;
      n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %0b expected 0", err_o); else n_pass++;
      n_checks++; if (rdata_o !== '0) $display("FAIL reset_rdata: got %0h expected 0", rdata_o); else n_pass++;
      n_checks++; if (irq_o !== 1'b0) $display("FAIL reset_irq: got %0b expected 0", irq_o); else n_pass++;
      rst_ni = 1'b1;
      csr_access(1'b0, CSR_MHPM_COUNTER_3, '0);
      n_checks++; if (rv !== 1'b1) $display("FAIL reset_read_rvalid: got %0b expected 1", rv); else n_pass++;
      n_checks++; if (rd !== 64'd0) $display("FAIL reset_cnt3: got %0d expected 0", rd); else n_pass++;
      n_checks++; if (er !== 1'b0) $display("FAIL reset_read_err: got %0b expected 0", er); else n_pass++;
      @(negedge clk_i);
      n_checks++; if (rvalid_o !== 1'b0) $display("FAIL rvalid_single_cycle: got %0b expected 0", rvalid_o); else n_pass++;
   endtask

   task automatic test_basic_count();
      csr_access(1'b1, CSR_MHPM_EVENT_3, 64'd1);
      ev[1] = 2'd2;
      repeat (10) @(negedge clk_i);
      ev = '0;
      csr_access(1'b0, CSR_MHPM_COUNTER_3, '0);
      n_checks++; if (rd !== 64'd20) $display("FAIL count_cnt3: got %0d expected 20", rd); else n_pass++;
      csr_access(1'b0, CSR_MHPM_EVENT_3, '0);
      n_checks++; if (rd !== 64'd1) $display("FAIL count_sel0: got %0d expected 1", rd); else n_pass++;
   endtask

   task automatic test_write_priority();
      csr_access(1'b1, CSR_MHPM_EVENT_3 + 12'd1, 64'd2);
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b1; addr_i = CSR_MHPM_COUNTER_3 + 12'd1; wdata_i = 64'd100;
      ev[1] = 2'd1; ev[2] = 2'd3;
      @(negedge clk_i);
      req_i = 1'b0; we_i = 1'b0; ev = '0;
      n_checks++; if (rvalid_o !== 1'b1 || err_o !== 1'b0) $display("FAIL wr_resp: got rvalid=%0b err=%0b expected 1/0", rvalid_o, err_o); else n_pass++;
      csr_access(1'b0, CSR_MHPM_COUNTER_3 + 12'd1, '0);
      n_checks++; if (rd !== 64'd100) $display("FAIL wr_prio_cnt4: got %0d expected 100", rd); else n_pass++;
      csr_access(1'b0, CSR_MHPM_COUNTER_3, '0);
      n_checks++; if (rd !== 64'd21) $display("FAIL wr_other_cnt3: got %0d expected 21", rd); else n_pass++;
      // Debug freeze.
      debug_mode_i = 1'b1; ev[1] = 2'd1; ev[2] = 2'd3;
      repeat (5) @(negedge clk_i);
      debug_mode_i = 1'b0; ev = '0;
      csr_access(1'b0, CSR_MHPM_COUNTER_3 + 12'd1, '0);
      n_checks++; if (rd !== 64'd100) $display("FAIL debug_cnt4: got %0d expected 100", rd); else n_pass++;
      csr_access(1'b0, CSR_MHPM_COUNTER_3, '0);
      n_checks++; if (rd !== 64'd21) $display("FAIL debug_cnt3: got %0d expected 21", rd); else n_pass++;
      // Inhibit bit 4 only.
      csr_access(1'b1, CSR_MCOUNTINHIBIT, 64'h10);
      ev[1] = 2'd1; ev[2] = 2'd3;
      repeat (5) @(negedge clk_i);
      ev = '0;
      csr_access(1'b0, CSR_MHPM_COUNTER_3 + 12'd1, '0);
      n_checks++; if (rd !== 64'd100) $display("FAIL inhibit_cnt4: got %0d expected 100", rd); else n_pass++;
      csr_access(1'b0, CSR_MHPM_COUNTER_3, '0);
      n_checks++; if (rd !== 64'd26) $display("FAIL inhibit_cnt3: got %0d expected 26", rd); else n_pass++;
      csr_access(1'b0, CSR_MCOUNTINHIBIT, '0);
      n_checks++; if (rd !== 64'h10) $display("FAIL inhibit_read: got %0h expected 10", rd); else n_pass++;
      csr_access(1'b1, CSR_MCOUNTINHIBIT, 64'h0);
   endtask

   task automatic test_overflow();
      csr_access(1'b1, CSR_MHPM_OVFIE, 64'd1);
      csr_access(1'b1, CSR_MHPM_COUNTER_3, {XLEN{1'b1}});
      @(negedge clk_i);
      ev[1] = 2'd1;
      @(negedge clk_i);
      ev = '0;
      n_checks++; if (irq_o !== 1'b0) $display("FAIL ovf_irq_early: got %0b expected 0", irq_o); else n_pass++;
      @(negedge clk_i);
      n_checks++; if (irq_o !== 1'b1) $display("FAIL ovf_irq_rise: got %0b expected 1", irq_o); else n_pass++;
      csr_access(1'b0, CSR_MHPM_COUNTER_3, '0);
      n_checks++; if (rd !== 64'd0) $display("FAIL ovf_wrap: got %0h expected 0", rd); else n_pass++;
      csr_access(1'b0, CSR_MHPM_OVF, '0);
      n_checks++; if (rd !== 64'd1) $display("FAIL ovf_flag: got %0h expected 1", rd); else n_pass++;
      csr_access(1'b1, CSR_MHPM_OVF, 64'd1);
      n_checks++; if (irq_o !== 1'b1) $display("FAIL ovf_irq_hold: got %0b expected 1", irq_o); else n_pass++;
      @(negedge clk_i);
      n_checks++; if (irq_o !== 1'b0) $display("FAIL ovf_irq_fall: got %0b expected 0", irq_o); else n_pass++;
      csr_access(1'b0, CSR_MHPM_OVF, '0);
      n_checks++; if (rd !== 64'd0) $display("FAIL ovf_cleared: got %0h expected 0", rd); else n_pass++;
      // W1C in the same cycle as a fresh overflow keeps the flag.
      csr_access(1'b1, CSR_MHPM_COUNTER_3, {XLEN{1'b1}});
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b1; addr_i = CSR_MHPM_OVF; wdata_i = 64'd1; ev[1] = 2'd1;
      @(negedge clk_i);
      req_i = 1'b0; we_i = 1'b0; ev = '0;
      csr_access(1'b0, CSR_MHPM_OVF, '0);
      n_checks++; if (rd !== 64'd1) $display("FAIL ovf_w1c_race: got %0h expected 1", rd); else n_pass++;
      csr_access(1'b1, CSR_MHPM_OVF, 64'd1);
      csr_access(1'b1, CSR_MHPM_OVFIE, 64'd0);
   endtask

   task automatic test_errors();
      csr_access(1'b0, CSR_MHPM_COUNTER_3H, '0);
      n_checks++; if (rv !== 1'b1 || er !== 1'b1 || rd !== '0) $display("FAIL err_hi_half: got rvalid=%0b err=%0b rdata=%0h expected 1/1/0", rv, er, rd); else n_pass++;
      csr_access(1'b0, CSR_MHPM_COUNTER_3 + 12'd7, '0);
      n_checks++; if (rv !== 1'b1 || er !== 1'b1 || rd !== '0) $display("FAIL err_idx7: got rvalid=%0b err=%0b rdata=%0h expected 1/1/0", rv, er, rd); else n_pass++;
      csr_access(1'b0, CSR_MHPM_COUNTER_3 + 12'd6, '0);
      n_checks++; if (er !== 1'b1) $display("FAIL err_idx6: got %0b expected 1", er); else n_pass++;
      csr_access(1'b1, CSR_MHPM_EVENT_3 + 12'd6, 64'd3);
      n_checks++; if (er !== 1'b1) $display("FAIL err_sel_idx6: got %0b expected 1", er); else n_pass++;
      csr_access(1'b0, 12'h123, '0);
      n_checks++; if (er !== 1'b1 || rd !== '0) $display("FAIL err_unmapped: got err=%0b rdata=%0h expected 1/0", er, rd); else n_pass++;
      @(negedge clk_i);
      n_checks++; if (rvalid_o !== 1'b0 || err_o !== 1'b0) $display("FAIL err_idle: got rvalid=%0b err=%0b expected 0/0", rvalid_o, err_o); else n_pass++;
   endtask

   task automatic test_threshold();
`ifdef HPM_THRESHOLD_EN
      csr_access(1'b1, CSR_MHPM_EVENT_3, 64'd1);
      csr_access(1'b1, CSR_MHPM_THRESHOLD_3, 64'd5);
      n_checks++; if (er !== 1'b0) $display("FAIL thr_write_err: got %0b expected 0", er); else n_pass++;
      ev[1] = 2'd1;
      repeat (5) @(negedge clk_i);
      n_checks++; if (irq_o !== 1'b0) $display("FAIL thr_irq_early: got %0b expected 0", irq_o); else n_pass++;
      @(negedge clk_i);
      n_checks++; if (irq_o !== 1'b1) $display("FAIL thr_irq_rise: got %0b expected 1", irq_o); else n_pass++;
      ev = '0;
      csr_access(1'b1, CSR_MHPM_THRESHOLD_3, 64'd0);
      @(negedge clk_i);
      n_checks++; if (irq_o !== 1'b0) $display("FAIL thr_irq_fall: got %0b expected 0", irq_o); else n_pass++;
`else
      csr_access(1'b1, CSR_MHPM_THRESHOLD_3, 64'd5);
      n_checks++; if (er !== 1'b1 || rd !== '0) $display("FAIL thr_absent_wr: got err=%0b rdata=%0h expected 1/0", er, rd); else n_pass++;
      csr_access(1'b0, CSR_MHPM_THRESHOLD_3H, '0);
      n_checks++; if (er !== 1'b1) $display("FAIL thr_absent_rd: got %0b expected 1", er); else n_pass++;
      n_checks++; if (irq_o !== 1'b0) $display("FAIL thr_absent_irq: got %0b expected 0", irq_o); else n_pass++;
`endif
   endtask

   task automatic test_back_to_back();
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b0; addr_i = CSR_MHPM_COUNTER_3 + 12'd1;
      @(negedge clk_i);
      n_checks++; if (rvalid_o !== 1'b1 || rdata_o !== 64'd100) $display("FAIL b2b_first: got rvalid=%0b rdata=%0d expected 1/100", rvalid_o, rdata_o); else n_pass++;
      addr_i = CSR_MHPM_EVENT_3 + 12'd1;
      @(negedge clk_i);
      n_checks++; if (rvalid_o !== 1'b1 || rdata_o !== 64'd2) $display("FAIL b2b_second: got rvalid=%0b rdata=%0d expected 1/2", rvalid_o, rdata_o); else n_pass++;
      addr_i = CSR_MCOUNTINHIBIT;
      @(negedge clk_i);
      n_checks++; if (rvalid_o !== 1'b1 || rdata_o !== 64'd0) $display("FAIL b2b_third: got rvalid=%0b rdata=%0d expected 1/0", rvalid_o, rdata_o); else n_pass++;
      req_i = 1'b0;
      @(negedge clk_i);
      n_checks++; if (rvalid_o !== 1'b0) $display("FAIL b2b_end: got %0b expected 0", rvalid_o); else n_pass++;
   endtask

   task automatic test_reset_drop();
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b0; addr_i = CSR_MHPM_COUNTER_3 + 12'd1;
      rst_ni = 1'b0;
      @(negedge clk_i);
      n_checks++; if (rvalid_o !== 1'b0) $display("FAIL rstdrop_during: got %0b expected 0", rvalid_o); else n_pass++;
      repeat (2) @(negedge clk_i);
      req_i = 1'b0;
      rst_ni = 1'b1;
      @(negedge clk_i);
      n_checks++; if (rvalid_o !== 1'b0) $display("FAIL rstdrop_after: got %0b expected 0", rvalid_o); else n_pass++;
      csr_access(1'b0, CSR_MHPM_COUNTER_3 + 12'd1, '0);
      n_checks++; if (rd !== 64'd0) $display("FAIL rstdrop_cnt4: got %0d expected 0", rd); else n_pass++;
      csr_access(1'b0, CSR_MHPM_EVENT_3 + 12'd1, '0);
      n_checks++; if (rd !== 64'd0) $display("FAIL rstdrop_sel1: got %0d expected 0", rd); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_count();
      test_write_priority();
      test_overflow();
      test_errors();
      test_threshold();
      test_back_to_back();
      test_reset_drop();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hpm_counter_unit.md
HPM_COUNTER_UNIT -- requirements
Module: hpm_counter_unit

Interface
REQ-001 Parameters SHALL be: NumCounters, default 6, number of programmable counters (1..29); CntWidth, default 64, counter width (32..64); NumEvents, default 32, event inputs (≤256); IncWidth, default 2, per-event increment width.
REQ-002 clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 debug_mode_i  in  1  freezes all counting while high.
REQ-004 req_i  in  1  CSR access strobe; we_i  in  1  write enable, qualified by req_i.
REQ-005 addr_i  in  12  CSR address; wdata_i  in  XLEN  write data.
REQ-006 rdata_o  out  XLEN  read data; rvalid_o  out  1  response valid; err_o  out  1  access error, valid with rvalid_o.
REQ-007 event_inc_i  in  NumEvents x IncWidth  per-cycle event count, so multiple commit ports count correctly.
REQ-008 irq_o  out  1  level counter interrupt.

Function
REQ-009 Counter k SHALL be mapped at MHPM_COUNTER_3+k, its high half at MHPM_COUNTER_3H+k, its selector at MHPM_EVENT_3+k; inhibit register at MCOUNTINHIBIT; overflow status (OVF, bit k per counter, write-1-to-clear) and overflow interrupt enable (OVFIE) at package-defined addresses.
REQ-010 Each cycle counter k SHALL add event_inc_i[sel_k] when sel_k is nonzero and < NumEvents, inhibit bit k+3 is clear and debug_mode_i is low; sel_k zero or out of range adds nothing.
REQ-011 Addition SHALL wrap modulo 2^CntWidth; a carry out SHALL set OVF[k] in the same update.
REQ-012 A CSR write to a counter SHALL take priority over that cycle's increment and SHALL NOT set OVF; other counters keep counting.
REQ-013 A selector write SHALL load sel_k (low 8 bits) and clear counter k and OVF[k] in the same cycle.
REQ-014 OVF write-1-to-clear coinciding with a new overflow on the same bit SHALL leave the bit set.
REQ-015 Reads SHALL have one-cycle latency: rvalid_o high exactly one cycle after each req_i, rdata_o valid with it, zero otherwise.
REQ-016 Read values narrower than XLEN SHALL zero-extend; high-half bits above CntWidth SHALL read zero and ignore writes.
REQ-017 Unmapped addresses, counter index ≥ NumCounters, or high-half addresses when XLEN=64 SHALL return err_o=1, rdata_o=0 and change no state.
REQ-018 irq_o SHALL be registered: high the cycle after any (OVF & OVFIE) bit is set, low the cycle after all clear.
REQ-019 Back-to-back requests SHALL be accepted every cycle; no stall exists.

Reset
REQ-020 On rst_ni low: all counters, selectors, OVF, OVFIE, inhibit and thresholds zero; rdata_o=0, rvalid_o=0, err_o=0, irq_o=0.
REQ-021 Reset asserted with a request pending SHALL drop the response; no rvalid_o after release.

Configuration
REQ-022 Macro HPM_THRESHOLD_EN SHALL, when defined, add per-counter threshold registers at MHPM_THRESHOLD_3+k / _3H+k and OR (counter ≥ threshold, threshold nonzero) per counter into irq_o.
REQ-023 Without HPM_THRESHOLD_EN those addresses SHALL return err_o and irq_o SHALL depend only on OVF & OVFIE.

Structure
REQ-024 CSR address offsets, OVF/OVFIE addresses, event ID enum (L1 I/D miss, ITLB/DTLB miss, load, store, branch, mispredict, call, return, SB full, IF empty, stall) SHALL live in ariane_pkg.
REQ-025 One sub-module hpm_counter_slice SHALL hold one counter: increment, wrap, write priority, OVF flag, threshold compare; instantiated NumCounters times.

Verification
REQ-026 sel_0=1, event_inc_i[1]=2 for 10 cycles -> counter 3 reads 20.
REQ-027 Counter 3 written 2^CntWidth-1, OVFIE[0]=1, one increment -> counter 0, OVF[0]=1, irq_o high next cycle; W1C OVF -> irq_o low.
REQ-028 Write counter 4 = 100 in a cycle with increment 3 -> reads 100; debug_mode_i or inhibit bit 4 high for 5 cycles -> unchanged.
REQ-029 Read MHPM_COUNTER_3H with XLEN=64, or index 7 with NumCounters=6 -> err_o=1, rdata_o=0, rvalid_o one cycle later.
REQ-030 HPM_THRESHOLD_EN, threshold_3=5, +1/cycle -> irq_o rises the cycle after count reaches 5; without macro, threshold write -> err_o=1.
